// File: rtl/ras_stack.sv
// Circular return-address stack with combinational top-of-stack and flow-through on empty.
// Optional single-level checkpoint/restore built when RAS_CHECKPOINT_EN is defined.
module ras_stack #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int ADDR  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              empty,
  output logic              full,
  output logic [ADDR:0]     count,
  output logic              overflow,
  output logic              underflow,
  input  logic              ckpt_save,
  input  logic              ckpt_restore
);

  localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);

  logic [WIDTH-1:0] ram [DEPTH];

  logic [ADDR-1:0]  tos_q, tos_d;
  logic [ADDR:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             we;
  logic [ADDR-1:0]  waddr;
  logic [WIDTH-1:0] wdata;
  logic             restore;

`ifdef RAS_CHECKPOINT_EN
  logic [ADDR-1:0]  snap_tos_q;
  logic [ADDR:0]    snap_cnt_q;
  logic [WIDTH-1:0] snap_data_q;

  assign restore = ckpt_restore;

  // Restore wins over save, so a snapshot is only taken when not restoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_tos_q  <= '0;
      snap_cnt_q  <= '0;
      snap_data_q <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      snap_tos_q  <= tos_q;
      snap_cnt_q  <= count_q;
      snap_data_q <= ram[tos_q];
    end
  end
`else
  logic unused_ckpt;
  assign unused_ckpt = ckpt_save ^ ckpt_restore;
  assign restore     = 1'b0;
`endif

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign dout      = empty ? din : ram[tos_q];

  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    we          = 1'b0;
    waddr       = tos_q;
    wdata       = din;
    if (restore) begin
`ifdef RAS_CHECKPOINT_EN
      tos_d   = snap_tos_q;
      count_d = snap_cnt_q;
      we      = 1'b1;
      waddr   = snap_tos_q;
      wdata   = snap_data_q;
`endif
    end else if (push && !pop) begin
      tos_d = tos_q + 1'b1;
      we    = 1'b1;
      waddr = tos_q + 1'b1;
      if (full) overflow_d = 1'b1;
      else      count_d    = count_q + 1'b1;
    end else if (pop && !push) begin
      if (empty) begin
        underflow_d = 1'b1;
      end else begin
        tos_d   = tos_q - 1'b1;
        count_d = count_q - 1'b1;
      end
    end else if (push && pop) begin
      // Replace top; on empty the value only flows through to dout.
      we = !empty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

endmodule

// File: tb/tb_ras_stack.sv
// Directed self-checking bench for ras_stack; checkpoint scenario runs when RAS_CHECKPOINT_EN is defined.
module tb_ras_stack;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0, pop = 1'b0, ckpt_save = 1'b0, ckpt_restore = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        empty, full, overflow, underflow;
  logic [4:0]  count;
  int checks = 0;
  int errors = 0;

  ras_stack #(.DEPTH(16), .WIDTH(32), .ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din), .dout(dout),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .underflow(underflow), .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; ckpt_save = 0; ckpt_restore = 0;
  endtask

  task automatic test_reset();
    idle(); din = 32'h55; rst_n = 0; #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses: got ovf=%b udf=%b exp 0/0", overflow, underflow); end
    checks++; if (dout !== 32'h55) begin errors++; $display("FAIL reset_dout: got %h exp 00000055", dout); end
    tick(); rst_n = 1; tick();
  endtask

  task automatic test_push_pop();
    logic [31:0] vals [3];
    vals[0] = 32'h100; vals[1] = 32'h104; vals[2] = 32'h108;
    for (int i = 0; i < 3; i++) begin
      push = 1; din = vals[i]; tick();
      checks++; if (count !== 5'(i+1) || dout !== vals[i]) begin errors++; $display("FAIL push_%0d: got cnt=%0d dout=%h exp cnt=%0d dout=%h", i, count, dout, i+1, vals[i]); end
    end
    push = 0; pop = 1; din = 32'hDEAD;
    for (int i = 2; i >= 0; i--) begin
      #1;
      checks++; if (dout !== vals[i] || count !== 5'(i+1)) begin errors++; $display("FAIL pop_%0d: got dout=%h cnt=%0d exp dout=%h cnt=%0d", i, dout, count, vals[i], i+1); end
      tick();
    end
    idle(); din = 32'h77; #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || dout !== 32'h77) begin errors++; $display("FAIL pop_empty: got cnt=%0d empty=%b dout=%h exp 0/1/00000077", count, empty, dout); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i <= 16; i++) begin
      push = 1; din = 32'(i); tick();
      checks++; if (overflow !== (i == 16)) begin errors++; $display("FAIL ovf_push_%0d: got ovf=%b exp %b", i, overflow, (i == 16)); end
    end
    idle();
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL ovf_full: got cnt=%0d full=%b exp 16/1", count, full); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len: got %b exp 0", overflow); end
    pop = 1; din = 32'hFFFF;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (dout !== 32'(16 - k)) begin errors++; $display("FAIL ovf_pop_%0d: got %h exp %h", k, dout, 32'(16 - k)); end
      tick();
    end
    idle();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL ovf_drain: got cnt=%0d empty=%b udf=%b exp 0/1/0", count, empty, underflow); end
  endtask

  task automatic test_underflow();
    pop = 1; tick(); idle();
    checks++; if (underflow !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL udf_pulse: got udf=%b cnt=%0d exp 1/0", underflow, count); end
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_pulse_len: got %b exp 0", underflow); end
    push = 1; pop = 1; din = 32'hABC; #1;
    checks++; if (dout !== 32'hABC) begin errors++; $display("FAIL flow_through: got %h exp 00000abc", dout); end
    tick(); idle();
    checks++; if (count !== 5'd0 || underflow !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL flow_state: got cnt=%0d udf=%b ovf=%b exp 0/0/0", count, underflow, overflow); end
  endtask

  task automatic test_replace();
    push = 1; din = 32'h1A0; tick();
    din = 32'h200; tick();
    pop = 1; din = 32'h300; tick(); idle(); din = 32'h0;
    checks++; if (dout !== 32'h300 || count !== 5'd2 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL replace: got dout=%h cnt=%0d ovf=%b udf=%b exp 00000300/2/0/0", dout, count, overflow, underflow); end
    pop = 1; tick(); idle();
    checks++; if (dout !== 32'h1A0 || count !== 5'd1) begin errors++; $display("FAIL replace_below: got dout=%h cnt=%0d exp 000001a0/1", dout, count); end
    pop = 1; tick(); idle();
  endtask

  task automatic test_checkpoint();
    push = 1; din = 32'h1A0; tick();
    din = 32'h200; tick(); idle();
    ckpt_save = 1; tick(); idle();
    pop = 1; tick();
    push = 1; din = 32'h999; tick();
    pop = 0; din = 32'h555; tick(); idle();
    checks++; if (dout !== 32'h555 || count !== 5'd2) begin errors++; $display("FAIL ckpt_pre: got dout=%h cnt=%0d exp 00000555/2", dout, count); end
    ckpt_restore = 1; tick(); idle();
`ifdef RAS_CHECKPOINT_EN
    checks++; if (count !== 5'd2 || dout !== 32'h200) begin errors++; $display("FAIL ckpt_restore: got cnt=%0d dout=%h exp 2/00000200", count, dout); end
    ckpt_restore = 1; push = 1; din = 32'h777; tick(); idle();
    checks++; if (count !== 5'd2 || dout !== 32'h200 || overflow !== 1'b0) begin errors++; $display("FAIL ckpt_beats_push: got cnt=%0d dout=%h ovf=%b exp 2/00000200/0", count, dout, overflow); end
`else
    checks++; if (count !== 5'd2 || dout !== 32'h555) begin errors++; $display("FAIL ckpt_ignored: got cnt=%0d dout=%h exp 2/00000555", count, dout); end
`endif
  endtask

  task automatic test_reset_mid();
    rst_n = 0; #1; rst_n = 1; tick();
    for (int i = 0; i < 5; i++) begin push = 1; din = 32'h40 + 32'(i); tick(); end
    idle();
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL mid_count: got %0d exp 5", count); end
    pop = 1; push = 0; #2; rst_n = 0; #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL mid_async: got cnt=%0d empty=%b full=%b ovf=%b udf=%b exp 0/1/0/0/0", count, empty, full, overflow, underflow); end
    idle(); din = 32'h123; #1;
    checks++; if (dout !== 32'h123) begin errors++; $display("FAIL mid_dout: got %h exp 00000123", dout); end
    rst_n = 1; ckpt_restore = 1; tick(); idle();
    checks++; if (count !== 5'd0 || empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL mid_restore: got cnt=%0d empty=%b udf=%b exp 0/1/0", count, empty, underflow); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_checkpoint();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
